// File: rtl/puf_ctrl_pkg.sv
// Shared state encoding, timing defaults and width helper for the arbiter-PUF race controller.
// Used by the controller top, its vote counter and anything that needs the default timing.
package puf_ctrl_pkg;

  localparam int DEF_N_STAGES   = 64;
  localparam int DEF_VOTE_N     = 5;
  localparam int DEF_SETTLE_CYC = 4;
  localparam int DEF_FIRE_CYC   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_FIRE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  // Bits needed to hold values 0..v-1; callers pass max+1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/puf_vote_counter.sv
// Purpose: counts arbiter ones over VOTE_N races and registers the majority/stability verdict.
// Latency: verdict registered on the edge of the final sample. Backpressure: none, driven by FSM strobes.
// Stability compare exists only when PUF_STABILITY_EN is defined.
module puf_vote_counter
  import puf_ctrl_pkg::*;
#(
  parameter int VOTE_N = DEF_VOTE_N,
  parameter int CW     = clog2(VOTE_N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          sample,
  input  logic          arb,
  output logic [CW-1:0] ones,
  output logic          last,
  output logic          resp_bit,
  output logic          resp_stable
);

  logic [CW-1:0] trial;
  logic [CW-1:0] ones_nxt;

  assign ones_nxt = ones + CW'(arb);
  assign last     = (trial == CW'(VOTE_N - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      ones     <= '0;
      trial    <= '0;
      resp_bit <= 1'b0;
    end else if (clear) begin
      ones  <= '0;
      trial <= '0;
    end else if (sample) begin
      ones  <= ones_nxt;
      trial <= trial + CW'(1);
      // Verdict uses the count including this final sample.
      if (last) resp_bit <= (ones_nxt > CW'(VOTE_N / 2));
    end
  end

`ifdef PUF_STABILITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_stable <= 1'b0;
    end else if (sample && last) begin
      resp_stable <= (ones_nxt == '0) || (ones_nxt == CW'(VOTE_N));
    end
  end
`else
  assign resp_stable = 1'b0;
`endif

endmodule

// File: rtl/puf_race_ctrl.sv
// Purpose: sequences VOTE_N arbiter-PUF races per challenge and returns the majority response bit.
// Latency: resp_valid 1+VOTE_N*(SETTLE_CYC+FIRE_CYC+1) cycles after request handshake. Backpressure: holds DONE until resp_ready; req_ready only in IDLE.
// Optional PUF_STABILITY_EN adds the all-samples-agree flag on resp_stable.
module puf_race_ctrl
  import puf_ctrl_pkg::*;
#(
  parameter int N_STAGES   = DEF_N_STAGES,
  parameter int VOTE_N     = DEF_VOTE_N,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int FIRE_CYC   = DEF_FIRE_CYC,
  localparam int CW        = clog2(VOTE_N + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [N_STAGES-1:0] req_challenge,
  input  logic [N_STAGES-1:0] tune,
  output logic [N_STAGES-1:0] sel_top,
  output logic [N_STAGES-1:0] sel_btm,
  output logic                launch,
  input  logic                arb_out,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic                resp_bit,
  output logic [CW-1:0]       resp_ones,
  output logic                resp_stable
);

  localparam int TMAX = (SETTLE_CYC > FIRE_CYC) ? SETTLE_CYC : FIRE_CYC;
  localparam int TW   = clog2(TMAX + 1);

  state_t                state, state_nxt;
  logic [TW-1:0]         tmr, tmr_nxt;
  logic [N_STAGES-1:0]   chal_q, btm_q;
  logic                  last_trial;

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_DONE);

  always_comb begin
    state_nxt = state;
    tmr_nxt   = '0;
    case (state)
      ST_IDLE:   if (req_valid) state_nxt = ST_LOAD;
      ST_LOAD:   state_nxt = ST_SETTLE;
      ST_SETTLE: begin
        if (tmr == TW'(SETTLE_CYC - 1)) state_nxt = ST_FIRE;
        else tmr_nxt = tmr + TW'(1);
      end
      ST_FIRE: begin
        if (tmr == TW'(FIRE_CYC - 1)) state_nxt = ST_SAMPLE;
        else tmr_nxt = tmr + TW'(1);
      end
      ST_SAMPLE: state_nxt = last_trial ? ST_DONE : ST_SETTLE;
      ST_DONE:   if (resp_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Launch is registered from the next state so the chain sees a glitch-free edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      tmr     <= '0;
      launch  <= 1'b0;
      chal_q  <= '0;
      btm_q   <= '0;
      sel_top <= '0;
      sel_btm <= '0;
    end else begin
      state  <= state_nxt;
      tmr    <= tmr_nxt;
      launch <= (state_nxt == ST_FIRE) || (state_nxt == ST_SAMPLE);
      if (state == ST_IDLE && req_valid) begin
        chal_q <= req_challenge;
        btm_q  <= req_challenge ^ tune;
      end
      if (state == ST_LOAD) begin
        sel_top <= chal_q;
        sel_btm <= btm_q;
      end
    end
  end

  puf_vote_counter #(
    .VOTE_N (VOTE_N),
    .CW     (CW)
  ) u_vote (
    .clk         (clk),
    .rst         (rst),
    .clear       (state == ST_LOAD),
    .sample      (state == ST_SAMPLE),
    .arb         (arb_out),
    .ones        (resp_ones),
    .last        (last_trial),
    .resp_bit    (resp_bit),
    .resp_stable (resp_stable)
  );

endmodule
